// File: rtl/row_data_assembler_if.sv
// Host byte-stream handshake into row_data_assembler.
// A byte transfers on a rising clock edge where byte_valid & byte_ready.
interface row_data_assembler_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/row_data_assembler.sv
// Receives 50-byte frames (header, 48 data bytes, XOR checksum) and emits one
// 384-bit row write per good frame; bad or stalled frames pulse frame_error.
module row_data_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  row_data_assembler_if.slave  bus,
  output logic [383:0]         row_data,
  output logic [3:0]           row_data_row_addr,
  output logic [1:0]           row_data_panel_addr,
  output logic                 row_data_write_enable,
  output logic                 frame_error,
  output logic [15:0]          frame_count
);

  typedef enum logic [1:0] {IDLE, DATA, CHECK, WRITE} state_t;

  // Gap value one idle cycle before the terminal count is reached.
  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        accept;
  logic        in_frame;
  logic        timeout;
  logic        error_next;
  logic [7:0]  running_xor;
  logic [5:0]  byte_idx;
  logic [15:0] gap_cnt;
  logic [15:0] frame_cnt;

  assign accept      = bus.byte_valid & bus.byte_ready;
  assign in_frame    = (state == DATA) || (state == CHECK);
  assign timeout     = in_frame && !accept && (gap_cnt == GAP_LAST);
  assign frame_count = frame_cnt;

  always_comb begin
    state_next            = state;
    error_next            = 1'b0;
    row_data_write_enable = 1'b0;
    bus.byte_ready        = 1'b1;
    case (state)
      IDLE: begin
        if (accept && bus.byte_in[7]) state_next = DATA;
      end
      DATA: begin
        if (accept) begin
          if (byte_idx == 6'd47) state_next = CHECK;
        end else if (timeout) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      CHECK: begin
        if (accept) begin
          if ((running_xor ^ bus.byte_in) == 8'h00) begin
            state_next = WRITE;
          end else begin
            state_next = IDLE;
            error_next = 1'b1;
          end
        end else if (timeout) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      WRITE: begin
        row_data_write_enable = 1'b1;
        bus.byte_ready        = 1'b0;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      frame_error <= error_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_data            <= '0;
      row_data_row_addr   <= '0;
      row_data_panel_addr <= '0;
      running_xor         <= '0;
      byte_idx            <= '0;
      gap_cnt             <= '0;
      frame_cnt           <= '0;
    end else begin
      if (accept) begin
        gap_cnt <= '0;
      end else if (in_frame) begin
        gap_cnt <= gap_cnt + 16'd1;
      end

      if (accept && (state == IDLE) && bus.byte_in[7]) begin
        row_data_panel_addr <= bus.byte_in[5:4];
        row_data_row_addr   <= bus.byte_in[3:0];
        running_xor         <= bus.byte_in;
        byte_idx            <= '0;
      end

      if (accept && (state == DATA)) begin
        row_data    <= {row_data[375:0], bus.byte_in};
        running_xor <= running_xor ^ bus.byte_in;
        byte_idx    <= byte_idx + 6'd1;
      end

      if (state == WRITE) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_row_data_assembler.sv
// Directed-frame bench for row_data_assembler with a queue-based scoreboard:
// the driver pushes expected strobe/error events, a negedge monitor pops them.
module tb_row_data_assembler;

  localparam time CLK_PERIOD = 10;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [383:0] row_data;
  logic [3:0]   row_data_row_addr;
  logic [1:0]   row_data_panel_addr;
  logic         row_data_write_enable;
  logic         frame_error;
  logic [15:0]  frame_count;

  row_data_assembler_if bus ();

  row_data_assembler #(.TIMEOUT_CYCLES(10)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .bus                   (bus.slave),
    .row_data              (row_data),
    .row_data_row_addr     (row_data_row_addr),
    .row_data_panel_addr   (row_data_panel_addr),
    .row_data_write_enable (row_data_write_enable),
    .frame_error           (frame_error),
    .frame_count           (frame_count)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  typedef struct {
    bit          is_err;
    time         due;
    logic [1:0]  panel;
    logic [3:0]  row;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  time  we_times[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (row_data_write_enable === 1'b1 || frame_error === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk(row_data_write_enable ? "unexpected_strobe" : "unexpected_error", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event_time", 64'($time), 64'(e.due));
        chk("event_is_error", {63'd0, frame_error}, {63'd0, e.is_err});
        chk("event_is_strobe", {63'd0, row_data_write_enable}, {63'd0, !e.is_err});
        if (row_data_write_enable) begin
          we_times.push_back($time);
          chk("panel_addr", {62'd0, row_data_panel_addr}, {62'd0, e.panel});
          chk("row_addr", {60'd0, row_data_row_addr}, {60'd0, e.row});
          chk("row_first_byte", {56'd0, row_data[383:376]}, 64'h01);
          chk("row_mid_byte", {56'd0, row_data[199:192]}, 64'h18);
          chk("row_last_byte", {56'd0, row_data[7:0]}, 64'h30);
          chk("ready_low_in_strobe", {63'd0, bus.byte_ready}, 64'd0);
          chk("count_during_strobe", {48'd0, frame_count}, {48'd0, e.cnt});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] b);
    int unsigned guard;
    guard = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.byte_ready) chk("ready_wait_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic push_exp(input bit is_err, input time due, input logic [7:0] hdr,
                          input logic [15:0] cnt);
    exp_t e;
    e.is_err = is_err;
    e.due    = due;
    e.panel  = hdr[5:4];
    e.row    = hdr[3:0];
    e.cnt    = cnt;
    exp_q.push_back(e);
  endtask

  // Header, data 8'h01..8'h30, then checksum byte chk_b.
  task automatic frame(input logic [7:0] hdr, input logic [7:0] chk_b, input bit good,
                       input logic [15:0] cnt_during, input bit keep_valid);
    send(hdr);
    for (int i = 1; i <= 48; i++) send(8'(i));
    push_exp(!good, $time + CLK_PERIOD, hdr, cnt_during);
    send(chk_b);
    if (!keep_valid) bus.byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_row_data_zero"}, {63'd0, |row_data}, 64'd0);
    chk({tag, "_row_addr"}, {60'd0, row_data_row_addr}, 64'd0);
    chk({tag, "_panel_addr"}, {62'd0, row_data_panel_addr}, 64'd0);
    chk({tag, "_write_enable"}, {63'd0, row_data_write_enable}, 64'd0);
    chk({tag, "_frame_error"}, {63'd0, frame_error}, 64'd0);
    chk({tag, "_frame_count"}, {48'd0, frame_count}, 64'd0);
    chk({tag, "_byte_ready"}, {63'd0, bus.byte_ready}, 64'd1);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Good frame: header A5, checksum A5 ^ 30 = 95.
    frame(8'hA5, 8'h95, 1'b1, 16'd0, 1'b0);
    idle(2);
    chk("count_after_good", {48'd0, frame_count}, 64'd1);

    // Bad checksum, then a good frame recovers.
    frame(8'hA5, 8'h94, 1'b0, 16'd0, 1'b0);
    idle(2);
    chk("count_after_bad", {48'd0, frame_count}, 64'd1);
    frame(8'hA5, 8'h95, 1'b1, 16'd1, 1'b0);
    idle(2);
    chk("count_after_recover", {48'd0, frame_count}, 64'd2);

    // Resync: non-sync bytes dropped silently.
    send(8'h00);
    send(8'h7F);
    frame(8'h80, 8'hB0, 1'b1, 16'd2, 1'b0);
    idle(2);
    chk("count_after_resync", {48'd0, frame_count}, 64'd3);

    // Timeout after 10 idle cycles mid-frame.
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
    bus.byte_valid = 1'b0;
    push_exp(1'b1, $time + 10 * CLK_PERIOD, 8'hA5, 16'd3);
    idle(12);
    chk("count_after_timeout", {48'd0, frame_count}, 64'd3);

    // Byte lands exactly on the terminal-count cycle: frame continues.
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
    idle(9);
    for (int i = 4; i <= 48; i++) send(8'(i));
    push_exp(1'b0, $time + CLK_PERIOD, 8'hA5, 16'd3);
    send(8'h95);
    idle(2);
    chk("count_after_terminal_byte", {48'd0, frame_count}, 64'd4);

    // Reset after 20 data bytes.
    send(8'hA5);
    for (int i = 1; i <= 20; i++) send(8'(i));
    bus.byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // Header DA: bit6 ignored, panel 1, row A; checksum DA ^ 30 = EA.
    frame(8'hDA, 8'hEA, 1'b1, 16'd0, 1'b0);
    idle(2);
    chk("count_after_midreset", {48'd0, frame_count}, 64'd1);

    // Wrap with back-to-back frames.
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("count_preload", {48'd0, frame_count}, 64'hFFFE);
    frame(8'hA5, 8'h95, 1'b1, 16'hFFFE, 1'b1);
    frame(8'hA5, 8'h95, 1'b1, 16'hFFFF, 1'b0);
    idle(2);
    chk("count_wrap", {48'd0, frame_count}, 64'd0);
    if (we_times.size() >= 2)
      chk("b2b_period", 64'(we_times[we_times.size()-1] - we_times[we_times.size()-2]),
          64'(51 * CLK_PERIOD));
    else
      chk("b2b_strobe_count", 64'(we_times.size()), 64'd2);

    idle(3);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_event", 64'd0, 64'(e.due));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(200000 * CLK_PERIOD);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/row_data_assembler.md
# row_data_assembler

Byte-stream frame receiver that produces the row-write interface consumed by the cube `controller`: `row_data`, `row_data_row_addr`, `row_data_panel_addr` and `row_data_write_enable`.

- Host bytes arrive over a valid/ready byte interface, one frame per panel row.
- Each frame is checked with an XOR checksum and assembled into one 384-bit row.
- A valid frame produces a single-cycle write strobe; bad or stalled frames are dropped and flagged.

## Interface
- `TIMEOUT_CYCLES`, default 65535: idle cycles allowed between bytes inside a frame before the frame is aborted; maximum 65535 (16-bit counter).
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `byte_in` input 8: incoming stream byte.
- `byte_valid` input 1: `byte_in` is valid this cycle.
- `byte_ready` output 1: block can accept a byte; a byte is accepted on a rising edge where `byte_valid & byte_ready`.
- `row_data` output 384: assembled row shift register.
- `row_data_row_addr` output 4: row address from the frame header.
- `row_data_panel_addr` output 2: panel address from the frame header.
- `row_data_write_enable` output 1: one-cycle strobe; all row outputs are valid in this cycle.
- `frame_error` output 1: one-cycle pulse on a checksum mismatch or timeout.
- `frame_count` output 16: count of good frames, wraps at 65535 to 0.

## Operation
- Frame format is 50 bytes: header, 48 data bytes, checksum.
- Header byte:
  - bit7 = 1 (sync).
  - bit6 is ignored.
  - bits5:4 = panel address.
  - bits3:0 = row address.
- Checksum byte is chosen so the XOR of all 50 bytes equals 8'h00.
- FSM states are IDLE, DATA, CHECK and WRITE.
- **IDLE**
  - Accepted byte with bit7 = 0: discarded silently, no error.
  - Accepted byte with bit7 = 1: latch the address fields, set the running XOR to the byte, clear the byte index, go to DATA.
- **DATA**
  - Each accepted byte is shifted in MSB-first: `row_data <= {row_data[375:0], byte_in}`. The first data byte therefore ends in `row_data[383:376]`.
  - The byte is XORed into the running XOR and the 6-bit index increments.
  - After the 48th byte (index 47), go to CHECK.
  - Data bytes have no sync restriction.
- **CHECK**
  - On the accepted byte, if `running_xor ^ byte_in == 0`, go to WRITE.
  - Otherwise pulse `frame_error` and go to IDLE.
- **WRITE** lasts exactly one cycle:
  - `row_data_write_enable` = 1.
  - `byte_ready` = 0.
  - `frame_count` increments.
  - Next state is IDLE.
- `byte_ready` is 1 in IDLE, DATA and CHECK, and 0 only in WRITE.
- `row_data` changes while a frame is being received. It is only guaranteed meaningful during the write-strobe cycle; it holds its value until the next accepted data byte.
- The address outputs change only when a header is accepted.
- **Timeout**
  - A 16-bit gap counter clears on every accepted byte and increments each cycle in DATA or CHECK without an accepted byte.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_error`, go to IDLE.
  - If an accepted byte and the terminal count occur in the same cycle, the byte wins and no timeout occurs.
- Reset can arrive mid-frame. The partial frame is lost, with no strobe and no error.

## Timing
- Reset values:
  - `byte_ready` = 1 (combinational from state IDLE).
  - All other outputs are 0, including `row_data`, both addresses and `frame_count`.
  - FSM is in IDLE.
- Latency: the checksum byte is accepted at edge N; `row_data_write_enable` is high for the cycle between edges N and N+1.
- At edge N+1 the FSM returns to IDLE, and a new header can be accepted at edge N+2.
- `frame_error` rises after the edge that accepts the bad checksum byte, or after the edge where the gap counter reaches its limit. It is high for one cycle.
- Minimum frame period is 51 cycles.

## Test plan
- **Good frame:** reset, then header 8'hA5 (panel 2, row 5), data bytes 8'h01..8'h30, then the correct checksum.
  - One strobe 1 cycle after the checksum is accepted.
  - Panel addr = 2, row addr = 5.
  - `row_data[383:376]` = 8'h01, `row_data[7:0]` = 8'h30.
  - `frame_count` = 1, `byte_ready` low during the strobe.
- **Bad checksum:** same frame with checksum XOR 8'h01.
  - No strobe.
  - `frame_error` pulses 1 cycle.
  - `frame_count` unchanged.
  - The next good frame is accepted normally.
- **Resync:** bytes 8'h00, 8'h7F, then a good frame with header 8'h80.
  - Leading bytes are discarded with no error.
  - Strobe with panel 0, row 0.
- **Timeout:** `TIMEOUT_CYCLES` = 10, header plus 3 data bytes, then `byte_valid` low for 10 cycles.
  - `frame_error` pulses; FSM returns to IDLE; no strobe.
  - Repeat with a byte arriving exactly at terminal count: no error.
- **Reset mid-frame:** assert `reset_n` low after 20 data bytes.
  - All outputs return to reset values.
  - A subsequent good frame writes correctly.
- **Wrap and back-to-back:** preload 65535 good frames (or force `frame_count`), then send one more with `byte_valid` held high continuously.
  - `frame_count` wraps to 0.
  - Consecutive frames strobe every 51 cycles.
